// File: rtl/bif_sched_pkg.sv
// Shared types for the bus interface scheduler: FSM states, requester
// indices and the IO/CPU round-robin pick.
package bif_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    TERM = 3'd4,
    ERR  = 3'd5
  } state_e;

  typedef logic [1:0] rq_idx_t;

  localparam rq_idx_t REF = 2'd0;
  localparam rq_idx_t SEM = 2'd1;
  localparam rq_idx_t IO  = 2'd2;
  localparam rq_idx_t CPU = 2'd3;

  // On an IO/CPU tie the requester that was not served last wins.
  function automatic rq_idx_t rr_pick(input rq_idx_t last);
    return (last == IO) ? CPU : IO;
  endfunction

endpackage

// File: rtl/bif_phase_cnt.sv
// Shared phase/timeout counter: clear, load, enable, saturating increment and
// a terminal flag that rises on the i_term'th cycle after a clear.
module bif_phase_cnt #(
  parameter int CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_term_m1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Count starts at 0 on the first cycle, so the i_term'th cycle sees i_term-1.
  assign w_term_m1 = i_term - CNT_W'(1);
  assign o_tc      = (r_cnt >= w_term_m1);
  assign o_cnt     = r_cnt;

endmodule

// File: rtl/bif_bus_sched.sv
// Arbitrates four local requesters onto the bus interface and sequences each
// backplane cycle through request, address, data and completion phases.
module bif_bus_sched
  import bif_sched_pkg::*;
#(
  parameter int ADDR_CYC = 2,
  parameter int TOUT_CYC = 255,
  parameter int CNT_W    = 10
) (
  input  logic       OSC,
  input  logic       CLEAR_n,
  input  logic       REFRQ_n,
  input  logic       SEMRQ_n,
  input  logic       IORQ_n,
  input  logic       CRQ_n,
  input  logic       WRITE,
  output logic       REF_GNT_n,
  output logic       SEM_GNT_n,
  output logic       IO_GNT_n,
  output logic       CPU_GNT_n,
  output logic       BREQ_n,
  input  logic       BGNT_n,
  output logic       BAPR_n,
  output logic       BDAP_n,
  input  logic       BDRY_n,
  input  logic       BERROR_n,
  output logic       DONE_n,
  output logic       TOUT,
  output logic       ERR_n,
  output logic [2:0] DBG_STATE
);

  // Request/grant handshake: a requester holds its *RQ_n low until DONE_n is
  // seen with its grant; releasing it before the backplane grant abandons the
  // cycle silently, releasing it later has no effect on the running cycle.

  state_e          r_state;
  state_e          w_next;
  rq_idx_t         r_winner;
  rq_idx_t         r_rr_last;
  rq_idx_t         w_arb;
  logic            r_write;
  logic            r_tout_flag;
  logic            w_tout_cause;
  logic            w_any_req;
  logic            w_win_req_n;
  logic [3:0]      w_rq_n;
  logic [3:0]      w_gnt_n;
  logic            w_breq_on;
  logic            w_cnt_clr;
  logic            w_cnt_en;
  logic            w_tc;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_term;

  assign w_rq_n      = {CRQ_n, IORQ_n, SEMRQ_n, REFRQ_n};
  assign w_any_req   = ~&w_rq_n;
  assign w_win_req_n = w_rq_n[r_winner];

  always_comb begin
    w_arb = CPU;
    if (!REFRQ_n) begin
      w_arb = REF;
    end else if (!SEMRQ_n) begin
      w_arb = SEM;
    end else if (!IORQ_n && !CRQ_n) begin
      w_arb = rr_pick(r_rr_last);
    end else if (!IORQ_n) begin
      w_arb = IO;
    end else begin
      w_arb = CPU;
    end
  end

  assign w_cnt_clr = (w_next != r_state);
  assign w_cnt_en  = (r_state == REQ) || (r_state == ADDR) || (r_state == DATA);
  assign w_term    = (r_state == ADDR) ? CNT_W'(ADDR_CYC) : CNT_W'(TOUT_CYC);

  bif_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .i_clk      (OSC),
    .i_rst_n    (CLEAR_n),
    .i_clr      (w_cnt_clr),
    .i_en       (w_cnt_en),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_term     (w_term),
    .o_cnt      (w_cnt),
    .o_tc       (w_tc)
  );

  // BREQ_n drops on the second REQ cycle; the counter is cleared on entry and
  // saturates, so a non-zero count marks every REQ cycle after the first.
  assign w_breq_on = (r_state == REQ) && (w_cnt != '0);

  always_comb begin
    w_next       = r_state;
    w_tout_cause = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_next = REQ;
      end
      REQ: begin
        w_tout_cause = 1'b1;
        if (!BGNT_n && w_breq_on) begin
          w_next = ADDR;
        end else if (w_win_req_n) begin
          w_next = IDLE;
        end else if (w_tc) begin
          w_next = ERR;
        end
      end
      ADDR: begin
        if (w_tc) w_next = (r_winner == REF) ? TERM : DATA;
      end
      DATA: begin
        w_tout_cause = BERROR_n;
        if (!BERROR_n) begin
          w_next = ERR;
        end else if (!BDRY_n) begin
          w_next = TERM;
        end else if (w_tc) begin
          w_next = ERR;
        end
      end
      TERM:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge OSC or negedge CLEAR_n) begin
    if (!CLEAR_n) begin
      r_state     <= IDLE;
      r_winner    <= CPU;
      r_write     <= 1'b0;
      r_rr_last   <= CPU;
      r_tout_flag <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_any_req) begin
        r_winner <= w_arb;
        r_write  <= WRITE;
      end
      if (w_next == ERR) begin
        r_tout_flag <= w_tout_cause;
      end
      if (((r_state == TERM) || (r_state == ERR)) &&
          ((r_winner == IO) || (r_winner == CPU))) begin
        r_rr_last <= r_winner;
      end
    end
  end

  always_comb begin
    w_gnt_n = 4'b1111;
    if (r_state != IDLE) begin
      w_gnt_n[r_winner] = 1'b0;
    end
  end

  always_comb begin
    BREQ_n = 1'b1;
    BAPR_n = 1'b1;
    BDAP_n = 1'b1;
    DONE_n = 1'b1;
    TOUT   = 1'b0;
    ERR_n  = 1'b1;
    case (r_state)
      REQ:  BREQ_n = ~w_breq_on;
      ADDR: BAPR_n = 1'b0;
      DATA: BDAP_n = ~r_write;
      TERM: DONE_n = 1'b0;
      ERR: begin
        DONE_n = 1'b0;
        TOUT   = r_tout_flag;
        ERR_n  = r_tout_flag;
      end
      default: ;
    endcase
  end

  assign REF_GNT_n = w_gnt_n[REF];
  assign SEM_GNT_n = w_gnt_n[SEM];
  assign IO_GNT_n  = w_gnt_n[IO];
  assign CPU_GNT_n = w_gnt_n[CPU];
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_bif_bus_sched.sv
// Directed bench for bif_bus_sched: a per-cycle vector table for single
// transactions plus hand-written arbitration, timeout and reset sequences.
module tb_bif_bus_sched;
  import bif_sched_pkg::*;

  logic       OSC;
  logic       CLEAR_n;
  logic       REFRQ_n, SEMRQ_n, IORQ_n, CRQ_n, WRITE;
  logic       REF_GNT_n, SEM_GNT_n, IO_GNT_n, CPU_GNT_n;
  logic       BREQ_n, BGNT_n, BAPR_n, BDAP_n, BDRY_n, BERROR_n;
  logic       DONE_n, TOUT, ERR_n;
  logic [2:0] DBG_STATE;

  int n_checks = 0;
  int n_errors = 0;

  // Output order: {REF,SEM,IO,CPU}_GNT_n, BREQ_n, BAPR_n, BDAP_n, DONE_n, TOUT, ERR_n
  localparam logic [9:0] IDLE_O = 10'b1111_111_1_0_1;

  typedef struct packed {
    logic [3:0] rq_n;   // {REFRQ_n, SEMRQ_n, IORQ_n, CRQ_n}
    logic       wr;
    logic       bgnt_n;
    logic       bdry_n;
    logic       berr_n;
    logic [9:0] exp;
  } vec_t;

  vec_t vq[$];

  bif_bus_sched #(.ADDR_CYC(2), .TOUT_CYC(255), .CNT_W(10)) dut (
    .OSC       (OSC),
    .CLEAR_n   (CLEAR_n),
    .REFRQ_n   (REFRQ_n),
    .SEMRQ_n   (SEMRQ_n),
    .IORQ_n    (IORQ_n),
    .CRQ_n     (CRQ_n),
    .WRITE     (WRITE),
    .REF_GNT_n (REF_GNT_n),
    .SEM_GNT_n (SEM_GNT_n),
    .IO_GNT_n  (IO_GNT_n),
    .CPU_GNT_n (CPU_GNT_n),
    .BREQ_n    (BREQ_n),
    .BGNT_n    (BGNT_n),
    .BAPR_n    (BAPR_n),
    .BDAP_n    (BDAP_n),
    .BDRY_n    (BDRY_n),
    .BERROR_n  (BERROR_n),
    .DONE_n    (DONE_n),
    .TOUT      (TOUT),
    .ERR_n     (ERR_n),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial OSC = 1'b0;
  always #5 OSC = ~OSC;

  function automatic logic [9:0] outs();
    return {REF_GNT_n, SEM_GNT_n, IO_GNT_n, CPU_GNT_n,
            BREQ_n, BAPR_n, BDAP_n, DONE_n, TOUT, ERR_n};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] rq, input logic w, input logic g,
                        input logic r, input logic e);
    {REFRQ_n, SEMRQ_n, IORQ_n, CRQ_n} = rq;
    WRITE    = w;
    BGNT_n   = g;
    BDRY_n   = r;
    BERROR_n = e;
  endtask

  task automatic step();
    @(posedge OSC);
    #1;
  endtask

  task automatic do_reset();
    set_in(4'b1111, 1'b0, 1'b1, 1'b1, 1'b1);
    CLEAR_n = 1'b0;
    repeat (2) @(posedge OSC);
    #1;
    check("reset_outputs", 32'(outs()), 32'(IDLE_O));
    check("reset_state", 32'(DBG_STATE), 32'(IDLE));
    @(negedge OSC);
    CLEAR_n = 1'b1;
    step();
  endtask

  // ---------------- driver tasks ----------------
  task automatic add(input logic [3:0] rq, input logic w, input logic g,
                     input logic r, input logic e, input logic [9:0] exp);
    vq.push_back('{rq_n: rq, wr: w, bgnt_n: g, bdry_n: r, berr_n: e, exp: exp});
  endtask

  // Runs until a DONE_n cycle (bounded); reports the grant seen there and
  // whether a data-present phase occurred on the way.
  task automatic wait_done(output logic [3:0] gnt, output logic saw_bdap, output logic ok);
    ok       = 1'b0;
    saw_bdap = 1'b0;
    gnt      = 4'b1111;
    for (int i = 0; i < 60; i++) begin
      if (!BDAP_n) saw_bdap = 1'b1;
      if (!DONE_n) begin
        gnt = {REF_GNT_n, SEM_GNT_n, IO_GNT_n, CPU_GNT_n};
        ok  = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic expect_done(input string name, input logic [3:0] exp_gnt,
                             input logic exp_bdap);
    logic [3:0] gnt;
    logic       bdap;
    logic       ok;
    wait_done(gnt, bdap, ok);
    check({name, "_done_seen"}, 32'(ok), 32'd1);
    check({name, "_grant"}, 32'(gnt), 32'(exp_gnt));
    check({name, "_data_phase"}, 32'(bdap), 32'(exp_bdap));
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int n;
    int dones;
    logic found;
    logic [3:0] exp_q[$];

    CLEAR_n = 1'b0;
    set_in(4'b1111, 1'b0, 1'b1, 1'b1, 1'b1);

    // CPU read: grant at cycle 1, BREQ_n at 2, backplane grant at 4,
    // address 5-6, data 7-10 (ready at 10), DONE_n at 11.
    add(4'b1110, 0, 1, 1, 1, IDLE_O);
    add(4'b1110, 0, 1, 1, 1, 10'b1110_111_1_0_1);
    add(4'b1110, 0, 1, 1, 1, 10'b1110_011_1_0_1);
    add(4'b1110, 0, 1, 1, 1, 10'b1110_011_1_0_1);
    add(4'b1110, 0, 0, 1, 1, 10'b1110_011_1_0_1);
    add(4'b1110, 0, 1, 1, 1, 10'b1110_101_1_0_1);
    add(4'b1110, 0, 1, 1, 1, 10'b1110_101_1_0_1);
    add(4'b1110, 0, 1, 1, 1, 10'b1110_111_1_0_1);
    add(4'b1110, 0, 1, 1, 1, 10'b1110_111_1_0_1);
    add(4'b1110, 0, 1, 1, 1, 10'b1110_111_1_0_1);
    add(4'b1110, 0, 1, 0, 1, 10'b1110_111_1_0_1);
    add(4'b1111, 0, 1, 1, 1, 10'b1110_111_0_0_1);
    add(4'b1111, 0, 1, 1, 1, IDLE_O);
    // CPU write, WRITE dropped after latching; BERROR_n and BDRY_n together.
    add(4'b1110, 1, 0, 1, 1, IDLE_O);
    add(4'b1110, 0, 0, 1, 1, 10'b1110_111_1_0_1);
    add(4'b1110, 0, 0, 1, 1, 10'b1110_011_1_0_1);
    add(4'b1110, 0, 0, 1, 1, 10'b1110_101_1_0_1);
    add(4'b1110, 0, 0, 1, 1, 10'b1110_101_1_0_1);
    add(4'b1110, 0, 0, 0, 0, 10'b1110_110_1_0_1);
    add(4'b1111, 0, 1, 1, 1, 10'b1110_111_0_0_0);
    add(4'b1111, 0, 1, 1, 1, IDLE_O);
    // IO request withdrawn while waiting for the backplane grant.
    add(4'b1101, 0, 1, 1, 1, IDLE_O);
    add(4'b1101, 0, 1, 1, 1, 10'b1101_111_1_0_1);
    add(4'b1111, 0, 1, 1, 1, 10'b1101_011_1_0_1);
    add(4'b1111, 0, 1, 1, 1, IDLE_O);
    add(4'b1111, 0, 1, 1, 1, IDLE_O);

    do_reset();

    foreach (vq[i]) begin
      set_in(vq[i].rq_n, vq[i].wr, vq[i].bgnt_n, vq[i].bdry_n, vq[i].berr_n);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
      step();
    end

    // Priority: REF (no data phase), then SEM, then CPU.
    set_in(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_done("prio_ref", 4'b0111, 1'b0);
    REFRQ_n = 1'b1;
    step();
    expect_done("prio_sem", 4'b1011, 1'b1);
    SEMRQ_n = 1'b1;
    step();
    expect_done("prio_cpu", 4'b1110, 1'b1);
    CRQ_n = 1'b1;
    step();
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (!DONE_n) dones++;
      step();
    end
    check("prio_no_extra_done", 32'(dones), 32'd0);

    // Round robin from reset (last served = CPU): IO, CPU, IO, CPU.
    do_reset();
    exp_q = '{4'b1101, 4'b1110, 4'b1101, 4'b1110};
    set_in(4'b1100, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      expect_done($sformatf("rr%0d", k), exp_q.pop_front(), 1'b0);
      if (k < 3) step();
    end
    set_in(4'b1111, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    step();
    check("rr_idle_after", 32'(outs()), 32'(IDLE_O));

    // Timeout: backplane grant never arrives.
    set_in(4'b1110, 1'b0, 1'b1, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!CPU_GNT_n) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("tout_grant_seen", 32'(found), 32'd1);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      n++;
      if (TOUT) break;
    end
    check("tout_latency", 32'(n), 32'd255);
    check("tout_err_cycle", 32'(outs()), 32'(10'b1110_111_0_1_1));
    CRQ_n = 1'b1;
    step();
    check("tout_idle_after", 32'(outs()), 32'(IDLE_O));
    check("tout_state_after", 32'(DBG_STATE), 32'(IDLE));

    // Asynchronous reset in the middle of a write data phase.
    set_in(4'b1110, 1'b1, 1'b0, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!BDAP_n) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("rst_data_phase_seen", 32'(found), 32'd1);
    #2;
    CLEAR_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'(outs()), 32'(IDLE_O));
    check("rst_async_state", 32'(DBG_STATE), 32'(IDLE));
    set_in(4'b1111, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge OSC);
    CLEAR_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (!DONE_n) dones++;
    end
    check("rst_no_done", 32'(dones), 32'd0);
    check("rst_idle_after", 32'(outs()), 32'(IDLE_O));

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
